// File: rtl/mips_mem_responder.sv
// Unified instruction/data store for the multicycle MIPS core: it accepts one
// request at a time, inserts LATENCY wait states, then answers with a one-cycle ready pulse.
module mips_mem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy
);
    localparam int         AW  = $clog2(DEPTH);
    localparam logic [3:0] LAT = 4'(LATENCY);

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    state_t        state, state_nxt;
    mem_req_t      cur;
    logic [3:0]    cnt;
    logic [31:0]   mem [DEPTH];
    logic          accept, fire, fault;
    logic [AW-1:0] idx;

    // State register; busy is a flop of its own so that it leaves the block registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == WAIT);
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (req) state_nxt = WAIT;
            WAIT:    if (cnt == 4'd0) state_nxt = RESP;
            RESP:    state_nxt = req ? WAIT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        accept = req && (state != WAIT);
        fire   = (state == WAIT) && (cnt == 4'd0);
        idx    = cur.addr[AW+1:2];
        fault  = (cur.addr[1:0] != 2'b00) || (|cur.addr[31:AW+2]);
    end

    // RESP lasts exactly one cycle, so ready and err simply follow fire.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur   <= '0;
            cnt   <= 4'd0;
            rdata <= 32'd0;
            ready <= 1'b0;
            err   <= 1'b0;
        end else begin
            if (accept) begin
                cur <= '{we: we, addr: addr, wdata: wdata};
                cnt <= LAT;
            end else if ((state == WAIT) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
            ready <= fire;
            err   <= fire && fault;
            if (fire)
                rdata <= fault ? 32'd0 : (cur.we ? cur.wdata : mem[idx]);
        end
    end

    // Store contents survive reset; reset forces IDLE, so a pending write never fires.
    always_ff @(posedge clk) begin
        if (fire && cur.we && !fault)
            mem[idx] <= cur.wdata;
    end

endmodule

// File: tb/tb_mips_mem_responder.sv
// Scoreboard bench: a LATENCY=2 instance (index 0) and a LATENCY=0 instance
// (index 1), exercised one after the other against a reference model.
module tb_mips_mem_responder;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        req [2];
    logic        we;
    logic [31:0] addr, wdata;
    logic [31:0] rdata [2];
    logic        ready [2], err [2], busy [2];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_rc [2];

    typedef struct {
        int          d;
        int          rc;
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t q[$];

    logic [31:0] mm [2][64];

    mips_mem_responder #(.DEPTH(64), .LATENCY(2)) u_lat2 (
        .clk(clk), .reset_n(reset_n), .req(req[0]), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata[0]), .ready(ready[0]), .err(err[0]), .busy(busy[0]));

    mips_mem_responder #(.DEPTH(64), .LATENCY(0)) u_lat0 (
        .clk(clk), .reset_n(reset_n), .req(req[1]), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata[1]), .ready(ready[1]), .err(err[1]), .busy(busy[1]));

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic timeout(string tag);
        checks++;
        failures++;
        $display("FAIL %s timed out (cycle %0d)", tag, cyc);
    endtask

    function automatic int lat(int d);
        return (d == 0) ? 2 : 0;
    endfunction

    // Called at a negedge where the next posedge will accept the request.
    function automatic void push(int d, logic w, logic [31:0] a, logic [31:0] wd);
        exp_t e;
        logic f;
        f       = (a[1:0] != 2'b00) || (a[31:2] >= 30'd64);
        e.d     = d;
        e.rc    = cyc + 2 + lat(d);
        e.err   = f;
        e.rdata = f ? 32'd0 : (w ? wd : mm[d][a[7:2]]);
        if (w && !f) mm[d][a[7:2]] = wd;
        q.push_back(e);
        last_rc[d] = e.rc;
    endfunction

    task automatic wait_idle(int d);
        int g = 0;
        while (last_rc[d] > cyc && g < 40) begin
            @(negedge clk);
            g++;
        end
        if (last_rc[d] > cyc) timeout("wait_idle");
    endtask

    task automatic issue(int d, logic w, logic [31:0] a, logic [31:0] wd);
        wait_idle(d);
        req[d] = 1'b1;
        we     = w;
        addr   = a;
        wdata  = wd;
        push(d, w, a, wd);
        @(negedge clk);
        req[d] = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while (q.size() > 0 && g < 60) begin
            @(negedge clk);
            g++;
        end
        if (q.size() > 0) begin
            timeout("drain");
            q.delete();
        end
    endtask

    task automatic chk_reset_outputs(string tag, int d);
        chk({tag, "_ready"}, 32'(ready[d]), 32'd0);
        chk({tag, "_err"},   32'(err[d]),   32'd0);
        chk({tag, "_busy"},  32'(busy[d]),  32'd0);
        chk({tag, "_rdata"}, rdata[d],      32'd0);
    endtask

    task automatic mon(int d);
        logic due;
        chk($sformatf("busy%0d", d), 32'(busy[d]), 32'(last_rc[d] > cyc));
        due = 1'b0;
        if (q.size() > 0)
            due = (q[0].d == d) && (q[0].rc == cyc);
        chk($sformatf("ready%0d", d), 32'(ready[d]), 32'(due));
        if (due) begin
            if (ready[d]) begin
                chk($sformatf("rdata%0d", d), rdata[d], q[0].rdata);
                chk($sformatf("err%0d", d), 32'(err[d]), 32'(q[0].err));
            end
            void'(q.pop_front());
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        #1;
        for (int d = 0; d < 2; d++) mon(d);
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] keep;
        reset_n    = 1'b0;
        req[0]     = 1'b0;
        req[1]     = 1'b0;
        we         = 1'b0;
        addr       = '0;
        wdata      = '0;
        last_rc[0] = 0;
        last_rc[1] = 0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("rst_hold0", 0);
        chk_reset_outputs("rst_hold1", 1);
        reset_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs("rst_rel0", 0);

        // LATENCY=2: write/read, misaligned and out-of-range faults
        issue(0, 1'b1, 32'h10, 32'hDEADBEEF);
        issue(0, 1'b0, 32'h10, 32'h0);
        issue(0, 1'b0, 32'h12, 32'h0);
        issue(0, 1'b1, 32'h0, 32'h0BADF00D);
        issue(0, 1'b1, 32'h100, 32'h1);
        issue(0, 1'b0, 32'h0, 32'h0);
        for (int i = 1; i < 4; i++) issue(0, 1'b1, 32'(4 * i), 32'h1000 + 32'(i));
        drain();

        // req held high: only requests seen while idle or in RESP may be accepted
        for (int i = 0; i < 16; i++) begin
            req[0] = 1'b1;
            we     = 1'b0;
            addr   = 32'(4 * (i % 5));
            if (!(last_rc[0] > cyc)) push(0, 1'b0, addr, 32'h0);
            @(negedge clk);
        end
        req[0] = 1'b0;
        drain();

        // reset during WAIT drops the write and clears all outputs at once
        issue(0, 1'b1, 32'h20, 32'hA5A5A5A5);
        wait_idle(0);
        keep = mm[0][8];
        issue(0, 1'b1, 32'h20, 32'h12345678);
        #2 reset_n = 1'b0;
        #1;
        chk_reset_outputs("rst_mid", 0);
        q.delete();
        last_rc[0] = 0;
        mm[0][8]   = keep;
        @(negedge clk);
        reset_n = 1'b1;
        issue(0, 1'b0, 32'h20, 32'h0);
        drain();

        // LATENCY=0 instance
        issue(1, 1'b1, 32'h14, 32'hCAFEF00D);
        issue(1, 1'b0, 32'h14, 32'h0);
        for (int i = 0; i < 8; i++) begin
            req[1] = 1'b1;
            we     = (i % 2 == 1);
            addr   = 32'h14;
            wdata  = 32'h5000 + 32'(i);
            if (!(last_rc[1] > cyc)) push(1, we, addr, wdata);
            @(negedge clk);
        end
        req[1] = 1'b0;
        issue(1, 1'b0, 32'h14, 32'h0);
        issue(1, 1'b0, 32'h101, 32'h0);
        drain();

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mips_mem_responder.md
# mips_mem_responder

Memory responder for the multicycle MIPS core. The control FSM acts as the initiator: during fetch it issues reads at the PC, and during MemRead/MemWrite it issues accesses at the ALU result. This block answers each request after a programmable number of wait states and returns read data with a one-cycle `ready` strobe. It holds one unified, word-organised instruction/data store and flags misaligned or out-of-range accesses.

## Interface
- `DEPTH`, default 64: number of 32-bit words in the store. Must be a power of two, at least 2.
- `LATENCY`, default 2: wait cycles inserted between request accept and response, 0..15.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `req`  in  1: request strobe. Sampled only on edges where `busy`=0.
- `we`  in  1: 1 = write, 0 = read. Captured with `req`.
- `addr`  in  32: byte address. Captured with `req`.
- `wdata`  in  32: write data. Captured with `req`.
- `rdata`  out  32: read data, registered. Valid while `ready`=1.
- `ready`  out  1: one-cycle response strobe, registered.
- `err`  out  1: access fault, qualified by `ready`.
- `busy`  out  1: 1 while a request is outstanding and not yet answered (state WAIT).

## Operation
- **States:** IDLE, WAIT, RESP.
- **Accept.** In IDLE or RESP with `req`=1:
  - latch `we`, `addr`, `wdata`;
  - load the 4-bit counter `cnt` with `LATENCY`;
  - go to WAIT.
- **No request.** In RESP with `req`=0, go to IDLE. IDLE with `req`=0 stays in IDLE.
- **WAIT, `cnt`≠0:** decrement `cnt` and stay in WAIT.
- **WAIT, `cnt`=0:** go to RESP and perform the access on the same edge:
  - fault = (`addr[1:0]`≠0) or (`addr[31:2]` ≥ `DEPTH`);
  - fault: `err`←1, `rdata`←0, no store write;
  - read without fault: `rdata`←`mem[addr[log2(DEPTH)+1:2]]`, `err`←0;
  - write without fault: `mem[index]`←`wdata`, `rdata`←`wdata` (write-through echo), `err`←0;
  - `ready`←1 on this edge.
- **RESP:** leaving RESP clears `ready` and `err`.
- **Holding.** `rdata` holds its value until the next response. It is not cleared when `ready` falls.
- **While busy.** `req` asserted while `busy`=1 is ignored, with no queueing. The initiator must hold or re-issue it.
- **Reset.**
  - Asserting `reset_n`=0 forces IDLE with `cnt`=0, `ready`=0, `err`=0, `busy`=0, `rdata`=0.
  - An in-flight request is dropped. A pending write is not performed.
  - Store contents are not reset.
- **Store.** Inferred as `DEPTH`×32 registers. One access per response; no simultaneous read and write.

## Timing
- A request accepted at edge E0 gets its response on edge E0+`LATENCY`+1:
  - `ready`, `rdata` and `err` are updated on that edge;
  - `ready` stays high for exactly one cycle and drops at E0+`LATENCY`+2.
- The write commits at edge E0+`LATENCY`+1. A read accepted at that edge or later returns the new data.
- `busy` is 1 from E0 to E0+`LATENCY`+1, i.e. `LATENCY`+1 cycles.
- Earliest next accept is edge E0+`LATENCY`+2 (in RESP). Sustained throughput is one access per `LATENCY`+2 cycles.
- With `LATENCY`=0, `ready` rises at E0+1.
- All outputs are registered, with no combinational path from inputs to outputs.
- Reset asserts asynchronously. Deassertion is taken on a clock edge; the first accept is possible on the first edge after deassertion.

## Test plan
- **Reset values.** Hold `reset_n`=0, then release. Expect `ready`=`err`=`busy`=0 and `rdata`=0.
- **Write then read, `LATENCY`=2.**
  - Write 0xDEADBEEF to 0x10, accepted at E0. Expect `busy`=1 for 3 cycles, `ready` pulse at E3 only, `rdata`=0xDEADBEEF, `err`=0.
  - Read 0x10, accepted at E4. Expect `ready` at E7 with 0xDEADBEEF.
- **Faults.**
  - Read at 0x12 (misaligned): expect `ready`=1 with `err`=1 and `rdata`=0.
  - Write 0x1 to 0x100 with `DEPTH`=64 (out of range): expect `err`=1, and a later read of word 0 is unchanged.
- **Ignored and back-to-back requests.** Hold `req`=1 continuously with varying addresses.
  - Accepts occur only at E0, E4, E8, …
  - Requests presented while `busy`=1 have no effect.
  - `ready` pulses at E3, E7, …
- **Reset mid-write.** Accept a write of 0x12345678 to 0x20, then pulse `reset_n` low during WAIT. Expect all outputs to return to reset values immediately. Expect a subsequent read of 0x20 to return the prior contents, not 0x12345678.
- **`LATENCY`=0 build.** Write then read word 5. Expect `ready` at E0+1, next accept at E0+2, and readback of the written value.
